vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Purpose : parametrised VGA raster timing with pixel requests issued ahead of the beam.
// Latency : display outputs (colour, syncs, blank) lag the oReq* outputs by LAT+1 pixel enables.
// Backpr. : none; iPIX_CE is the only stall, and every register holds while it is low.
//
// Ports:
//   iCLK, iRST          system clock, synchronous active-high reset
//   iPIX_CE             pixel clock enable
//   oReqValid/X/Y       pixel request (coordinates inside the active area, else 0)
//   iRed/iGreen/iBlue   host colour, valid LAT enables after the matching request
//   oVGA_R/G/B          colour to DAC, forced to 0 while blanked
//   oVGA_H/V_SYNC       sync pulses, active level HS_POL / VS_POL
//   oVGA_BLANK          1 = active video; oVGA_SYNC tied 0
//   oFrameStart         one-iCLK pulse when the counter becomes (0,0)
//   oVBlankStart        one-iCLK pulse when the counter reaches the first line after active video
module vga_timing_gen #(
  parameter int   COLOR_W = 10,
  parameter int   CNT_W   = 11,
  parameter int   H_SYNC  = 96,
  parameter int   H_BACK  = 48,
  parameter int   H_ACT   = 640,
  parameter int   H_FRONT = 16,
  parameter int   V_SYNC  = 2,
  parameter int   V_BACK  = 33,
  parameter int   V_ACT   = 480,
  parameter int   V_FRONT = 10,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   LAT     = 2
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iPIX_CE,
  output logic               oReqValid,
  output logic [CNT_W-1:0]   oReqX,
  output logic [CNT_W-1:0]   oReqY,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oFrameStart,
  output logic               oVBlankStart
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int H_END   = H_START + H_ACT;
  localparam int V_END   = V_START + V_ACT;

  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_START_C  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_START_C  = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_VBLANK_C = CNT_W'(V_END);

  if (LAT < 0 || LAT > 8) begin : g_bad_lat
    $error("vga_timing_gen: LAT must be in 0..8");
  end
  if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_cnt
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  // ---------------- counter stage ----------------
  logic [CNT_W-1:0] hc, vc, hc_nxt, vc_nxt;
  // run is clear after reset so that the first enable loads (0,0) rather
  // than stepping past it; that enable is the one that flags frame start.
  logic             run;

  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    if (run) begin
      if (hc == H_LAST_C) begin
        hc_nxt = '0;
        vc_nxt = (vc == V_LAST_C) ? '0 : vc + 1'b1;
      end else begin
        hc_nxt = hc + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hc           <= '0;
      vc           <= '0;
      run          <= 1'b0;
      oFrameStart  <= 1'b0;
      oVBlankStart <= 1'b0;
    end else begin
      oFrameStart  <= iPIX_CE && (hc_nxt == '0) && (vc_nxt == '0);
      oVBlankStart <= iPIX_CE && (hc_nxt == '0) && (vc_nxt == V_VBLANK_C);
      if (iPIX_CE) begin
        hc  <= hc_nxt;
        vc  <= vc_nxt;
        run <= 1'b1;
      end
    end
  end

  // ---------------- request stage ----------------
  logic in_h, in_v, in_act;
  logic s1_hs, s1_vs;

  assign in_h   = (int'(hc) >= H_START) && (int'(hc) < H_END);
  assign in_v   = (int'(vc) >= V_START) && (int'(vc) < V_END);
  assign in_act = in_h && in_v;

  // Held at reset values until the counter has actually presented (0,0),
  // so the first pixel is never duplicated into the pipeline.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oReqValid <= 1'b0;
      oReqX     <= '0;
      oReqY     <= '0;
      s1_hs     <= ~HS_POL;
      s1_vs     <= ~VS_POL;
    end else if (iPIX_CE && run) begin
      oReqValid <= in_act;
      oReqX     <= in_act ? hc - H_START_C : '0;
      oReqY     <= in_act ? vc - V_START_C : '0;
      s1_hs     <= (int'(hc) < H_SYNC) ? HS_POL : ~HS_POL;
      s1_vs     <= (int'(vc) < V_SYNC) ? VS_POL : ~VS_POL;
    end
  end

  // ---------------- LAT-deep delay of hs/vs/de ----------------
  // oReqValid doubles as the stage-1 display-enable.
  logic dl_hs, dl_vs, dl_de;

  if (LAT == 0) begin : g_nodelay
    assign {dl_hs, dl_vs, dl_de} = {s1_hs, s1_vs, oReqValid};
  end else begin : g_delay
    logic [2:0] sr [LAT];
    always_ff @(posedge iCLK) begin
      if (iRST) begin
        for (int i = 0; i < LAT; i++) sr[i] <= {~HS_POL, ~VS_POL, 1'b0};
      end else if (iPIX_CE) begin
        sr[0] <= {s1_hs, s1_vs, oReqValid};
        for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
      end
    end
    assign {dl_hs, dl_vs, dl_de} = sr[LAT-1];
  end

  // ---------------- output stage ----------------
  // Host colour is captured on the same edge as the delayed de, which is
  // exactly LAT enables after its request: colour, sync and blank line up.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
      oVGA_H_SYNC <= ~HS_POL;
      oVGA_V_SYNC <= ~VS_POL;
      oVGA_BLANK  <= 1'b0;
    end else if (iPIX_CE) begin
      oVGA_R      <= dl_de ? iRed   : '0;
      oVGA_G      <= dl_de ? iGreen : '0;
      oVGA_B      <= dl_de ? iBlue  : '0;
      oVGA_H_SYNC <= dl_hs;
      oVGA_V_SYNC <= dl_vs;
      oVGA_BLANK  <= dl_de;
    end
  end

  assign oVGA_SYNC = 1'b0;

endmodule
